// File: rtl/axi_mm_axis_reader.sv
// axi_mm_axis_reader
//
// Reads a block of memory over AXI4 and sends it out as one AXI-Stream frame.
// A command gives a start byte address and a byte length. The block splits the
// read into INCR bursts. No burst crosses a 4 KiB page and no burst is longer
// than MAX_BURST_LEN beats. Only one burst is outstanding at a time. Returned
// beats pass through a one-deep output register. The final beat of the command
// carries tlast and a tkeep mask trimmed to the byte length. When the command
// finishes, sts_valid pulses for one cycle. sts_error is set with it if any
// beat had a nonzero RRESP or a misplaced RLAST.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_addr, cmd_len              command: aligned start address, byte count
//   cmd_valid, cmd_ready           command handshake
//   sts_valid, sts_error           completion pulse and error flag
//   m_axi_ar*                      AXI4 read address channel (master)
//   m_axi_r*                       AXI4 read data channel (master)
//   m_axis_t*                      AXI-Stream output (master)

module axi_mm_axis_reader #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int ADDR_WIDTH    = 34,
  parameter int ID_WIDTH      = 6,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,

  output logic                  sts_valid,
  output logic                  sts_error,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int BYTE_LANES = DATA_WIDTH/8;
  localparam int OFFSET     = $clog2(BYTE_LANES);
  localparam int REM_WIDTH  = LEN_WIDTH - OFFSET + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REM_WIDTH-1:0]  remaining;
  logic [8:0]            burst;
  logic [8:0]            beat_cnt;
  logic [KEEP_WIDTH-1:0] last_keep;
  logic                  err;
  logic                  init_done;

  logic [LEN_WIDTH:0]    len_round;
  logic [REM_WIDTH-1:0]  cmd_beats;
  logic [OFFSET-1:0]     cmd_tail;
  logic [KEEP_WIDTH-1:0] cmd_keep;
  logic [8:0]            cmd_burst;
  logic [8:0]            next_burst;
  logic                  burst_last;
  logic                  final_beat;
  logic                  r_hs;
  logic                  out_free;

  // The read ID is not used: only one burst is in flight at a time.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  // The burst length is the smallest of three limits: the beats still owed,
  // the burst cap, and the beats left before the next 4 KiB page.
  function automatic logic [8:0] burst_calc(input logic [REM_WIDTH-1:0] rem,
                                            input logic [11:0] page_off);
    logic [12:0] page_bytes;
    logic [31:0] r;
    logic [31:0] p;
    logic [31:0] m;
    logic [31:0] b;
    page_bytes = 13'h1000 - {1'b0, page_off};
    r = 32'(rem);
    p = 32'(page_bytes >> OFFSET);
    m = 32'(MAX_BURST_LEN);
    b = r;
    if (m < b) b = m;
    if (p < b) b = p;
    return b[8:0];
  endfunction

  assign len_round  = {1'b0, cmd_len} + (LEN_WIDTH+1)'(BYTE_LANES - 1);
  assign cmd_beats  = len_round[LEN_WIDTH:OFFSET];
  assign cmd_tail   = cmd_len[OFFSET-1:0];
  assign cmd_keep   = (cmd_tail == '0) ? '1
                    : ((KEEP_WIDTH'(1) << cmd_tail) - KEEP_WIDTH'(1));
  assign cmd_burst  = burst_calc(cmd_beats, cmd_addr[11:0]);
  assign next_burst = burst_calc(remaining, addr[11:0]);

  // The remaining count is reduced at the AR handshake. This means remaining==0
  // during RD marks the final burst of the command.
  assign burst_last = (beat_cnt == burst - 9'd1);
  assign final_beat = burst_last && (remaining == '0);

  assign out_free     = !m_axis_tvalid || m_axis_tready;
  assign m_axi_rready = (state == S_RD) && out_free;
  assign r_hs         = m_axi_rvalid && m_axi_rready;

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(OFFSET);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;

  // Command FSM: owns the address/length bookkeeping, the AR channel and status.
  // cmd_ready stays low for one extra cycle after reset release, because
  // init_done has to come up first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      remaining     <= '0;
      burst         <= '0;
      beat_cnt      <= '0;
      last_keep     <= '0;
      err           <= 1'b0;
      init_done     <= 1'b0;
      cmd_ready     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      sts_valid     <= 1'b0;
      sts_error     <= 1'b0;
    end else begin
      init_done <= 1'b1;
      sts_valid <= 1'b0;
      sts_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr          <= cmd_addr;
            remaining     <= cmd_beats;
            burst         <= cmd_burst;
            last_keep     <= cmd_keep;
            err           <= 1'b0;
            beat_cnt      <= '0;
            m_axi_araddr  <= cmd_addr;
            m_axi_arlen   <= 8'(cmd_burst - 9'd1);
            m_axi_arvalid <= 1'b1;
            cmd_ready     <= 1'b0;
            state         <= S_AR;
          end else begin
            cmd_ready <= init_done;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            addr          <= addr + (ADDR_WIDTH'(burst) << OFFSET);
            remaining     <= remaining - REM_WIDTH'(burst);
            state         <= S_RD;
          end
        end
        S_RD: begin
          if (r_hs) begin
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != burst_last)) begin
              err <= 1'b1;
            end
            if (burst_last) begin
              beat_cnt <= '0;
              if (remaining != '0) begin
                burst         <= next_burst;
                m_axi_araddr  <= addr;
                m_axi_arlen   <= 8'(next_burst - 9'd1);
                m_axi_arvalid <= 1'b1;
                state         <= S_AR;
              end else begin
                state <= S_DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        default: begin
          // Report status only once the last beat can leave. The output
          // register must be empty or be handing off its final beat this cycle.
          if (out_free) begin
            sts_valid <= 1'b1;
            sts_error <= err;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  // One-deep output register. rready is only high when this register can take
  // a beat, so every accepted R beat has a place to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (r_hs) begin
      m_axis_tdata  <= m_axi_rdata;
      m_axis_tkeep  <= final_beat ? last_keep : '1;
      m_axis_tlast  <= final_beat;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_mm_axis_reader.sv
module tb_axi_mm_axis_reader;

  logic         clk;
  logic         rst_n;
  logic [33:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         sts_valid;
  logic         sts_error;
  logic [5:0]   m_axi_arid;
  logic [33:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arlock;
  logic [3:0]   m_axi_arcache;
  logic [2:0]   m_axi_arprot;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [5:0]   m_axi_rid;
  logic [511:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;

  axi_mm_axis_reader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .sts_valid(sts_valid), .sts_error(sts_error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    logic [33:0] addr;
    logic [7:0]  len;
  } ar_t;

  beat_t exp_beats[$];
  ar_t   exp_ar[$];
  logic  exp_sts[$];

  int   checks = 0;
  int   errors = 0;
  logic ignore_out = 1'b0;
  logic tready_rand = 1'b0;
  logic rand_mode = 1'b0;
  int   err_beat = 0;
  int   cmd_beat = 0;

  // 100 MHz clock; inputs change on the falling edge, sampling is 2ns later
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a pure function of the byte address
  function automatic logic [511:0] beat_data(input logic [33:0] a);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = (a[31:0] + 32'(w*4)) ^ 32'hC3A5_0000;
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectAr(input logic [33:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar.push_back(e);
  endtask

  task automatic issueCmd(input logic [33:0] a, input int len);
    bit done;
    done = 0;
    @(negedge clk);
    cmd_addr  = a;
    cmd_len   = 16'(len);
    cmd_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      #2;
      if (cmd_ready) done = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept: got no cmd_ready expected cmd_ready within 500 cycles");
    end
  endtask

  task automatic waitDone(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_beats.size() == 0 && exp_sts.size() == 0 && exp_ar.size() == 0) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d beats pending expected 0", name, exp_beats.size());
      exp_beats.delete();
      exp_sts.delete();
      exp_ar.delete();
    end
  endtask

  // Queue the frame and status the command should produce, then issue it
  task automatic applyStimulus(input string name, input logic [33:0] a, input int len,
                               input logic [63:0] last_keep, input int inj, input logic exp_err);
    int    n;
    beat_t b;
    n = (len + 63) / 64;
    for (int i = 0; i < n; i++) begin
      b.data = beat_data(a + 34'(i*64));
      b.keep = (i == n-1) ? last_keep : '1;
      b.last = (i == n-1);
      exp_beats.push_back(b);
    end
    exp_sts.push_back(exp_err);
    err_beat = inj;
    cmd_beat = 0;
    issueCmd(a, len);
    waitDone(name);
    $display("[TB] %s done", name);
  endtask

  // AXI slave: one burst at a time, optional random rvalid gaps and error injection
  logic [33:0] b_addr;
  logic [7:0]  b_len;
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rresp   = 2'b00;
    m_axi_rdata   = '0;
    m_axi_rid     = '0;
    forever begin
      @(negedge clk);
      if (rst_n && m_axi_arvalid) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (rst_n && m_axi_arvalid) begin
          m_axi_arready = 1'b1;
          b_addr = m_axi_araddr;
          b_len  = m_axi_arlen;
          @(negedge clk);
          m_axi_arready = 1'b0;
          begin : beats
            int  beat;
            bit  hs;
            beat = 0;
            hs   = 0;
            while (beat <= int'(b_len) && rst_n) begin
              if ((!m_axi_rvalid || hs) && rand_mode && $urandom_range(0, 1) == 0) begin
                m_axi_rvalid = 1'b0;
              end else begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = beat_data(b_addr + 34'(64*beat));
                m_axi_rlast  = (beat == int'(b_len));
                m_axi_rresp  = (cmd_beat + 1 == err_beat) ? 2'b10 : 2'b00;
              end
              #2;
              hs = 0;
              if (!rand_mode && beat > 0 && m_axi_rvalid && !tready_rand) begin
                checks++;
                if (!m_axi_rready) begin
                  errors++;
                  $display("[TB] FAIL no_bubble: got rready 0 expected 1 at beat %0d", beat);
                end
              end
              if (m_axi_rvalid && m_axi_rready) begin
                beat++;
                cmd_beat++;
                hs = 1;
              end
              @(negedge clk);
            end
          end
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
      end
    end
  end

  // Downstream ready: constant or random 50%
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output handshake
  initial begin
    beat_t b;
    ar_t   e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (m_axis_tvalid && !m_axis_tready) begin
          checks++;
          if (m_axi_rready) begin
            errors++;
            $display("[TB] FAIL rready_stall: got rready 1 expected 0 while output stalled");
          end
        end
        if (!ignore_out) begin
          if (m_axi_arvalid && m_axi_arready) begin
            if (exp_ar.size() == 0) checkOutput("unexpected_ar", m_axi_araddr, 512'h0);
            else begin
              e = exp_ar.pop_front();
              checkOutput("araddr", m_axi_araddr, e.addr);
              checkOutput("arlen", m_axi_arlen, e.len);
              checkOutput("arsize", m_axi_arsize, 3'd6);
              checkOutput("arburst", m_axi_arburst, 2'b01);
            end
          end
          if (m_axis_tvalid && m_axis_tready) begin
            if (exp_beats.size() == 0) checkOutput("unexpected_beat", m_axis_tvalid, 1'b0);
            else begin
              b = exp_beats.pop_front();
              checkOutput("tdata", m_axis_tdata, b.data);
              checkOutput("tkeep", m_axis_tkeep, b.keep);
              checkOutput("tlast", m_axis_tlast, b.last);
            end
          end
          if (sts_valid) begin
            checkOutput("sts_after_last", 512'(exp_beats.size()), 512'h0);
            if (exp_sts.size() == 0) checkOutput("unexpected_sts", sts_valid, 1'b0);
            else checkOutput("sts_error", sts_error, exp_sts.pop_front());
          end
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    checkOutput({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    checkOutput({tag, "_rready"}, m_axi_rready, 1'b0);
    checkOutput({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    checkOutput({tag, "_sts_valid"}, sts_valid, 1'b0);
    checkOutput({tag, "_sts_error"}, sts_error, 1'b0);
    checkOutput({tag, "_araddr"}, m_axi_araddr, 512'h0);
    checkOutput({tag, "_arlen"}, m_axi_arlen, 512'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (3) @(negedge clk);
    #2;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("cmd_ready_first_cycle", cmd_ready, 1'b0);
    @(negedge clk);
    #2;
    checkOutput("cmd_ready_second_cycle", cmd_ready, 1'b1);

    expectAr(34'h1000, 8'd0);
    applyStimulus("single_beat", 34'h1000, 64, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

    expectAr(34'h0, 8'd1);
    applyStimulus("partial_tail", 34'h0, 100, 64'h0000_000F_FFFF_FFFF, 0, 1'b0);

    expectAr(34'hFC0, 8'd0);
    expectAr(34'h1000, 8'd2);
    applyStimulus("page_split", 34'hFC0, 256, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

    expectAr(34'h0, 8'd15);
    expectAr(34'h400, 8'd15);
    applyStimulus("max_burst", 34'h0, 2048, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

    expectAr(34'h1F80, 8'd1);
    expectAr(34'h2000, 8'd15);
    expectAr(34'h2400, 8'd0);
    applyStimulus("page_and_max", 34'h1F80, 1200, 64'h0000_FFFF_FFFF_FFFF, 0, 1'b0);

    tready_rand = 1'b1;
    rand_mode   = 1'b1;
    expectAr(34'h2000, 8'd4);
    applyStimulus("random_flow", 34'h2000, 300, 64'h0000_0FFF_FFFF_FFFF, 0, 1'b0);
    expectAr(34'h1F80, 8'd1);
    expectAr(34'h2000, 8'd15);
    expectAr(34'h2400, 8'd0);
    applyStimulus("random_long", 34'h1F80, 1200, 64'h0000_FFFF_FFFF_FFFF, 0, 1'b0);
    tready_rand = 1'b0;
    rand_mode   = 1'b0;

    expectAr(34'h3000, 8'd3);
    applyStimulus("rresp_error", 34'h3000, 256, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1);
    expectAr(34'h5000, 8'd0);
    applyStimulus("error_cleared", 34'h5000, 64, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

    // Reset in the middle of a long read, then a clean command
    ignore_out = 1'b1;
    issueCmd(34'h0, 2048);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkIdleOutputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_beats.delete();
    exp_sts.delete();
    exp_ar.delete();
    @(negedge clk);
    #2;
    checkOutput("post_reset_rready", m_axi_rready, 1'b0);
    checkOutput("post_reset_cmd_ready", cmd_ready, 1'b0);
    checkOutput("post_reset_tvalid", m_axis_tvalid, 1'b0);
    repeat (3) @(negedge clk);
    ignore_out = 1'b0;
    expectAr(34'h0, 8'd1);
    applyStimulus("after_reset", 34'h0, 100, 64'h0000_000F_FFFF_FFFF, 0, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
